// File: rtl/dsp_result_collector.sv
// dsp_result_collector: reader end of the DSP48A1 register/bypass pipeline.
// It tracks in-flight operand sets with a tag pipeline and captures each P
// result into a small FIFO exactly when it arrives. Results go downstream
// through a valid/ready handshake. Credit-based admission keeps results plus
// in-flight items within the FIFO depth, so the DSP pipeline can free-run
// with its clock enable held high and no result is ever dropped.

module dsp_result_collector #(
  parameter int LATENCY = 2,
  parameter int WIDTH   = 48,
  parameter int DEPTH   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             CE_OUT,
  input  logic [WIDTH-1:0] P_IN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       occupancy
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]    DEPTH_C = 5'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [4:0]       fifo_count;
  logic [4:0]       inflight;
  logic             fire;
  logic             arrival;
  logic             push;
  logic             pop;

  // Credits come only from registered counts, never from out_ready, so a
  // pop frees a slot for admission from the following cycle onwards.
  assign occupancy = fifo_count + inflight;
  assign in_ready  = !RST && (occupancy < DEPTH_C);
  assign fire      = in_valid && in_ready;
  assign out_valid = !RST && (fifo_count != 5'd0);
  assign pop       = out_valid && out_ready;
  assign push      = arrival && !RST;
  assign CE_OUT    = !RST;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  generate
    if (LATENCY == 0) begin : g_comb
      // P_IN is combinational from the DSP inputs: the result lands in the fire cycle.
      assign arrival = fire;
    end else begin : g_pipe
      logic [LATENCY-1:0] vld;

      // Tag shift register marking which pipeline stages hold a live result.
      always_ff @(posedge CLK) begin
        if (RST) begin
          vld <= '0;
        end else begin
          vld[0] <= fire;
          for (int k = 1; k < LATENCY; k++) begin
            vld[k] <= vld[k-1];
          end
        end
      end

      assign arrival = vld[LATENCY-1];
    end
  endgenerate

  // Pointer and count bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      fifo_count <= fifo_count + 5'(push) - 5'(pop);
      inflight   <= inflight + 5'(fire) - 5'(arrival);
    end
  end

  // Result storage: P_IN is sampled only on an arrival, so idle-cycle junk never enters state.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= P_IN;
    end
  end

  // Invariants that the credit scheme is meant to guarantee.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!(push && !pop && (fifo_count == DEPTH_C)));
      assert (!(pop && (fifo_count == 5'd0)));
      assert (occupancy <= DEPTH_C);
    end
  end

endmodule

// File: tb/tb_dsp_result_collector.sv
// Bench for dsp_result_collector: three instances (LATENCY/DEPTH = 2/4, 0/2, 1/4)
// are exercised one at a time against a queue-based reference model.

module tb_dsp_result_collector;

  localparam int W = 48;

  typedef struct {
    int           due;
    logic [W-1:0] d;
  } fl_t;

  logic         clk = 1'b0;
  logic         rst       [3];
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         ce_out    [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [W-1:0] p_in      [3];
  logic [W-1:0] out_data  [3];
  logic [4:0]   occupancy [3];

  always #5 clk = ~clk;

  dsp_result_collector #(.LATENCY(2), .WIDTH(W), .DEPTH(4)) u_l2 (
    .CLK(clk), .RST(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .CE_OUT(ce_out[0]), .P_IN(p_in[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .occupancy(occupancy[0]));

  dsp_result_collector #(.LATENCY(0), .WIDTH(W), .DEPTH(2)) u_l0 (
    .CLK(clk), .RST(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .CE_OUT(ce_out[1]), .P_IN(p_in[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .occupancy(occupancy[1]));

  dsp_result_collector #(.LATENCY(1), .WIDTH(W), .DEPTH(4)) u_l1 (
    .CLK(clk), .RST(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .CE_OUT(ce_out[2]), .P_IN(p_in[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .occupancy(occupancy[2]));

  // Reference model: results waiting in the FIFO, and fired items with their arrival cycle.
  logic [W-1:0] mq[$];
  fl_t          fq[$];
  int           cur, lat, dep, cyc;
  int           checks, errors;
  logic         last_v, last_rdy;
  logic [W-1:0] last_d;
  logic [4:0]   last_occ;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance the model.
  task automatic step(input logic iv, input logic orr, input logic [W-1:0] val,
                      output logic dut_fire, output logic dut_pop);
    int           occ;
    logic         exp_rdy, exp_v, arrive;
    logic [W-1:0] exp_d;
    fl_t          e;
    occ     = mq.size() + fq.size();
    exp_rdy = (occ < dep);
    exp_v   = (mq.size() != 0);
    exp_d   = exp_v ? mq[0] : '0;
    if (iv && exp_rdy) begin
      e.due = cyc + lat;
      e.d   = val;
      fq.push_back(e);
    end
    arrive = (fq.size() != 0) && (fq[0].due == cyc);
    in_valid[cur]  = iv;
    out_ready[cur] = orr;
    p_in[cur]      = arrive ? fq[0].d : W'({$urandom(), $urandom()});
    #2;
    chk("in_ready",  64'(in_ready[cur]),  64'(exp_rdy));
    chk("out_valid", 64'(out_valid[cur]), 64'(exp_v));
    chk("out_data",  64'(out_data[cur]),  64'(exp_d));
    chk("occupancy", 64'(occupancy[cur]), 64'(occ));
    chk("ce_out",    64'(ce_out[cur]),    64'd1);
    last_v   = out_valid[cur];
    last_d   = out_data[cur];
    last_rdy = in_ready[cur];
    last_occ = occupancy[cur];
    dut_fire = iv && in_ready[cur];
    dut_pop  = out_valid[cur] && orr;
    if (exp_v && orr) void'(mq.pop_front());
    if (arrive) begin
      e = fq.pop_front();
      mq.push_back(e.d);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // One reset cycle with in_valid/out_ready high; everything buffered or in flight is lost.
  task automatic do_reset();
    rst[cur]       = 1'b1;
    in_valid[cur]  = 1'b1;
    out_ready[cur] = 1'b1;
    p_in[cur] = ((fq.size() != 0) && (fq[0].due == cyc)) ? fq[0].d : W'({$urandom(), $urandom()});
    #2;
    chk("rst_in_ready",  64'(in_ready[cur]),  64'd0);
    chk("rst_out_valid", 64'(out_valid[cur]), 64'd0);
    chk("rst_out_data",  64'(out_data[cur]),  64'd0);
    chk("rst_ce_out",    64'(ce_out[cur]),    64'd0);
    mq.delete();
    fq.delete();
    @(posedge clk);
    #1;
    rst[cur]       = 1'b0;
    in_valid[cur]  = 1'b0;
    out_ready[cur] = 1'b0;
    cyc++;
  endtask

  task automatic rand_run(input int nres, input int budget);
    int   nf, np;
    logic f, p;
    nf = 0;
    np = 0;
    for (int i = 0; i < budget; i++) begin
      if (nf >= nres && mq.size() == 0 && fq.size() == 0) break;
      step((nf < nres) && ($urandom_range(0, 3) != 0), $urandom_range(0, 2) != 0,
           W'({$urandom(), $urandom()}), f, p);
      if (f) nf++;
      if (p) np++;
    end
    chk("rand_fires", 64'(nf), 64'(nres));
    chk("rand_pops",  64'(np), 64'(nres));
  endtask

  initial begin
    logic         f, p;
    int           t0, first, peak, nv, nf, np;
    logic [W-1:0] got [3];
    checks = 0;
    errors = 0;
    cyc    = 0;
    for (int i = 0; i < 3; i++) begin
      rst[i]       = 1'b1;
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      p_in[i]      = '0;
    end
    repeat (2) @(posedge clk);
    #1;

    // ---- LATENCY=2, DEPTH=4 ----
    cur = 0; lat = 2; dep = 4;
    do_reset();
    t0 = cyc; first = -1; peak = 0; nv = 0;
    for (int i = 0; i < 9; i++) begin
      step(i < 3, 1'b1, W'(5 + i), f, p);
      if (last_v) begin
        if (first < 0) first = cyc - 1;
        if (nv < 3) got[nv] = last_d;
        nv++;
      end
      if (int'(last_occ) > peak) peak = int'(last_occ);
    end
    chk("p1_latency", 64'(first - t0), 64'd3);
    chk("p1_peak",    64'(peak),       64'd3);
    chk("p1_count",   64'(nv),         64'd3);
    for (int k = 0; k < 3; k++) chk("p1_data", 64'(got[k]), 64'(5 + k));

    nf = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, W'(100 + i), f, p);
      if (f) nf++;
    end
    chk("bp_fires", 64'(nf), 64'd4);
    step(1'b0, 1'b0, '0, f, p);
    chk("bp_head",   64'(last_d),   64'd100);
    chk("bp_valid",  64'(last_v),   64'd1);
    chk("bp_ready0", 64'(last_rdy), 64'd0);
    step(1'b0, 1'b1, '0, f, p);
    chk("bp_pop", 64'(p), 64'd1);
    step(1'b0, 1'b0, '0, f, p);
    chk("bp_credit", 64'(last_rdy), 64'd1);
    chk("bp_next",   64'(last_d),   64'd101);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0, f, p);

    rand_run(20, 300);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, W'(48'hA0 + i), f, p);
    chk("mid_occ", 64'(last_occ), 64'd3);
    do_reset();
    step(1'b0, 1'b1, '0, f, p);
    chk("post_rst_occ",   64'(last_occ), 64'd0);
    chk("post_rst_valid", 64'(last_v),   64'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, f, p);
    step(1'b1, 1'b1, 48'h1234, f, p);
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, '0, f, p);
      if (last_v) begin
        nv++;
        chk("post_rst_data", 64'(last_d), 64'h1234);
      end
    end
    chk("post_rst_count", 64'(nv), 64'd1);

    // ---- LATENCY=0, DEPTH=2 ----
    rst[cur] = 1'b1;
    cur = 1; lat = 0; dep = 2;
    do_reset();
    nf = 0; np = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, W'(nf), f, p);
      if (p) begin
        chk("l0_order", 64'(last_d), 64'(np));
        np++;
      end
      if (f) nf++;
    end
    chk("l0_fires", 64'(nf), 64'd12);
    chk("l0_pops",  64'(np), 64'd11);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, '0, f, p);
    rand_run(25, 400);

    // ---- LATENCY=1, DEPTH=4 ----
    rst[cur] = 1'b1;
    cur = 2; lat = 1; dep = 4;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, W'(48'h30 + i), f, p);
    chk("l1_pre_occ", 64'(last_occ), 64'd3);
    step(1'b0, 1'b1, '0, f, p);
    chk("l1_pushpop_head", 64'(last_d), 64'h30);
    step(1'b0, 1'b0, '0, f, p);
    chk("l1_after_occ",  64'(last_occ), 64'd3);
    chk("l1_after_head", 64'(last_d),   64'h31);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0, f, p);
    rand_run(30, 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
